// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: issues loads/stores over a req/ack handshake, stalls
// upstream while an access is outstanding and builds the MEM/WB input bundle.
module mem_stage_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ex_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  wb_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] write_data_in,
  input  logic [4:0]  write_back_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic        bus_err,
  output logic [1:0]  wb_out,
  output logic [31:0] alu_result_out,
  output logic [31:0] read_data_out,
  output logic [4:0]  write_back_out
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hold_q, hold_d;
  logic          err_q, err_d;

  logic mem_op_s;
  logic aligned_s;

  assign mem_op_s  = ex_valid & (mem_read | mem_write);
  assign aligned_s = (alu_result_in[1:0] == 2'b00);

  // Next-state and datapath register updates
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (mem_op_s && aligned_s) begin
          state_d = S_BUSY;
          req_d   = 1'b1;
          we_d    = mem_write;
          addr_d  = alu_result_in;
          wdata_d = write_data_in;
          cnt_d   = {CW{1'b0}};
          hold_d  = 32'd0;
          err_d   = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        // An ack on the final allowed cycle takes priority over the timeout.
        if (dmem_ack) begin
          hold_d  = we_q ? 32'd0 : dmem_rdata;
          req_d   = 1'b0;
          state_d = S_DONE;
        end else if (cnt_q == LAST_CNT) begin
          cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
          hold_d  = 32'd0;
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        err_d   = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
        err_d   = 1'b0;
      end
    endcase
  end

  // State and access registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      cnt_q   <= {CW{1'b0}};
      hold_q  <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
    end
  end

  // MEM/WB bundle, stall and error outputs
  always_comb begin
    stall          = 1'b0;
    bus_err        = 1'b0;
    wb_out         = 2'b00;
    alu_result_out = alu_result_in;
    write_back_out = write_back_in;
    read_data_out  = 32'd0;
    case (state_q)
      S_IDLE: begin
        if (mem_op_s) begin
          if (aligned_s) begin
            stall = 1'b1;
          end else begin
            bus_err = 1'b1;
          end
        end else begin
          wb_out = ex_valid ? wb_in : 2'b00;
        end
      end
      S_BUSY: begin
        stall = 1'b1;
      end
      S_DONE: begin
        read_data_out = hold_q;
        if (err_q) begin
          bus_err = 1'b1;
        end else begin
          wb_out = wb_in;
        end
      end
      default: begin
        stall = 1'b0;
      end
    endcase
    // The async reset leaves state at IDLE, but a memory op still on the inputs must not stall.
    if (!reset_n) begin
      stall   = 1'b0;
      bus_err = 1'b0;
      wb_out  = 2'b00;
    end else begin
      stall   = stall;
    end
  end

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;

endmodule
